// File: rtl/cr_crc16t_sched.sv
// Frame-granular arbiter sharing one CRC16T engine among N_REQ requesters; result valid 2 cycles after the eop beat.
// Result is held (all req_ready low) until res_ready; define CR_CRC16T_SCHED_STRICT_PRIO_EN for fixed-priority grant.
module cr_crc16t_sched #(
   parameter int          N_REQ      = 4,
   parameter logic [15:0] INIT_VALUE = 16'h0000,
   parameter int          ID_W       = $clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [N_REQ*64-1:0]  req_data,
   input  logic [N_REQ*8-1:0]   req_vbytes,
   input  logic [N_REQ-1:0]     req_eop,
   output logic [N_REQ-1:0]     req_ready,
   output logic [63:0]          crc_data_in,
   output logic                 crc_data_valid,
   output logic [7:0]           crc_data_vbytes,
   output logic                 crc_enable,
   output logic                 crc_init,
   output logic [15:0]          crc_init_value,
   input  logic [15:0]          crc_in,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [15:0]          res_crc,
   output logic [ID_W-1:0]      res_id,
   output logic [15:0]          res_nbytes,
   output logic                 busy
);
   typedef enum logic [2:0] {IDLE, INIT, DATA, FLUSH, RESULT} state_t;

   state_t          state, state_nxt;
   logic [ID_W-1:0] grant, pick;
   logic [15:0]     nbytes;
   logic [63:0]     data_arr [N_REQ];
   logic [7:0]      vb_arr   [N_REQ];
   logic            beat_acc, g_eop;
   logic [7:0]      eff_vb;
   logic [16:0]     nbytes_sum;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         data_arr[i] = req_data[64*i +: 64];
         vb_arr[i]   = req_vbytes[8*i +: 8];
      end
   end

`ifdef CR_CRC16T_SCHED_STRICT_PRIO_EN
   always_comb begin
      pick = '0;
      for (int i = N_REQ-1; i >= 0; i--)
         if (req_valid[ID_W'(i)]) pick = ID_W'(i);
   end
`else
   logic [ID_W-1:0] rr_ptr;

   // Walk downward so the last hit is the nearest requester at or after rr_ptr.
   always_comb begin
      logic [ID_W-1:0] idx;
      pick = '0;
      idx  = '0;
      for (int i = N_REQ-1; i >= 0; i--) begin
         idx = ID_W'((int'(rr_ptr) + i) % N_REQ);
         if (req_valid[idx]) pick = idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rr_ptr <= '0;
      else if (state == RESULT && res_ready)
         rr_ptr <= (int'(grant) == N_REQ-1) ? '0 : grant + 1'b1;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   assign g_eop    = req_eop[grant];
   assign beat_acc = (state == DATA) && req_valid[grant];
   // Only the eop beat may be partial; the engine always sees full words before it.
   assign eff_vb   = g_eop ? vb_arr[grant] : 8'hFF;

   always_comb begin
      state_nxt       = state;
      req_ready       = '0;
      crc_init        = 1'b0;
      crc_data_valid  = 1'b0;
      crc_data_in     = '0;
      crc_data_vbytes = '0;
      case (state)
         IDLE:   if (|req_valid) state_nxt = INIT;
         INIT: begin
            crc_init  = 1'b1;
            state_nxt = DATA;
         end
         DATA: begin
            req_ready[grant] = 1'b1;
            crc_data_valid   = req_valid[grant];
            crc_data_in      = data_arr[grant];
            crc_data_vbytes  = eff_vb;
            if (beat_acc && g_eop) state_nxt = FLUSH;
         end
         FLUSH:  state_nxt = RESULT;
         RESULT: if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign crc_init_value = INIT_VALUE;
   assign nbytes_sum     = {1'b0, nbytes} + 17'($countones(eff_vb));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant      <= '0;
         nbytes     <= '0;
         res_crc    <= '0;
         res_id     <= '0;
         res_nbytes <= '0;
         crc_enable <= 1'b0;
      end else begin
         crc_enable <= 1'b1;
         if (state == IDLE && |req_valid) grant <= pick;
         if (state == INIT)
            nbytes <= '0;
         else if (beat_acc)
            nbytes <= nbytes_sum[16] ? 16'hFFFF : nbytes_sum[15:0];
         if (state == FLUSH) begin
            res_crc    <= crc_in;
            res_id     <= grant;
            res_nbytes <= nbytes;
         end
      end
   end

   assign res_valid = (state == RESULT);
   assign busy      = (state != IDLE);
endmodule

// File: tb/tb_cr_crc16t_sched.sv
// Bench for cr_crc16t_sched: CRC16 engine model, per-requester beat sources and a byte-stream reference.
module tb_cr_crc16t_sched;
   localparam int          N  = 4;
   localparam int          IW = 2;
   localparam logic [15:0] IV = 16'h1D0F;

   typedef struct { logic [63:0] d; logic [7:0] vb; logic eop; int gap; } beat_t;
   typedef struct { logic [15:0] crc; logic [15:0] nb; } res_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid, req_eop, req_ready;
   logic [N*64-1:0] req_data;
   logic [N*8-1:0]  req_vbytes;
   logic [63:0]     crc_data_in;
   logic            crc_data_valid, crc_enable, crc_init;
   logic [7:0]      crc_data_vbytes;
   logic [15:0]     crc_init_value, crc_in;
   logic            res_valid, res_ready, busy;
   logic [15:0]     res_crc, res_nbytes;
   logic [IW-1:0]   res_id;

   beat_t      src_q [N][$];
   res_t       exp_q [N][$];
   int         gap_left [N];
   int         got_ids[$];
   logic [7:0] eng_vb[$];
   int         checks = 0;
   int         failures = 0;
   bit         rand_rdy = 1'b0;
   logic [15:0] eng = 16'h0000;

   cr_crc16t_sched #(.N_REQ(N), .INIT_VALUE(IV), .ID_W(IW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_vbytes(req_vbytes),
      .req_eop(req_eop), .req_ready(req_ready),
      .crc_data_in(crc_data_in), .crc_data_valid(crc_data_valid),
      .crc_data_vbytes(crc_data_vbytes), .crc_enable(crc_enable),
      .crc_init(crc_init), .crc_init_value(crc_init_value), .crc_in(crc_in),
      .res_valid(res_valid), .res_ready(res_ready), .res_crc(res_crc),
      .res_id(res_id), .res_nbytes(res_nbytes), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] b);
      logic [15:0] c;
      c = c_in ^ {b, 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h8BB7) : (c << 1);
      return c;
   endfunction

   function automatic logic [15:0] eng_upd(input logic [15:0] c_in, input logic [63:0] d, input logic [7:0] vb);
      logic [15:0] c;
      c = c_in;
      for (int j = 0; j < 8; j++) if (vb[j]) c = crc_byte(c, d[8*j +: 8]);
      return c;
   endfunction

   // Shared CRC16T engine: one-cycle registered crc.
   assign crc_in = eng;
   always @(posedge clk) begin
      if (crc_init) eng <= crc_init_value;
      else if (crc_enable && crc_data_valid) eng <= eng_upd(eng, crc_data_in, crc_data_vbytes);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic bit pending();
      for (int i = 0; i < N; i++) if (src_q[i].size() > 0 || exp_q[i].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (src_q[i].size() > 0 && gap_left[i] == 0) begin
            req_valid[i]          = 1'b1;
            req_data[64*i +: 64]  = src_q[i][0].d;
            req_vbytes[8*i +: 8]  = src_q[i][0].vb;
            req_eop[i]            = src_q[i][0].eop;
         end else begin
            req_valid[i]          = 1'b0;
            req_data[64*i +: 64]  = '0;
            req_vbytes[8*i +: 8]  = '0;
            req_eop[i]            = 1'b0;
         end
      end
      if (rand_rdy) res_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic bookkeep();
      logic [N-1:0] hs;
      hs = req_valid & req_ready;
      chk("data_valid_vs_handshake", crc_data_valid, |hs);
      chk("single_ready", ($countones(req_ready) <= 1), 1);
      for (int i = 0; i < N; i++) begin
         if (hs[i]) begin
            chk("beat_data", crc_data_in, src_q[i][0].d);
            chk("beat_vbytes", crc_data_vbytes, src_q[i][0].eop ? src_q[i][0].vb : 8'hFF);
            eng_vb.push_back(crc_data_vbytes);
            void'(src_q[i].pop_front());
            gap_left[i] = (src_q[i].size() > 0) ? src_q[i][0].gap : 0;
         end else if (gap_left[i] > 0) begin
            gap_left[i]--;
         end
      end
      if (res_valid && res_ready) begin
         got_ids.push_back(int'(res_id));
         chk("res_pending", (exp_q[res_id].size() > 0), 1);
         if (exp_q[res_id].size() > 0) begin
            chk("res_crc", res_crc, exp_q[res_id][0].crc);
            chk("res_nbytes", res_nbytes, exp_q[res_id][0].nb);
            void'(exp_q[res_id].pop_front());
         end
      end
   endtask

   task automatic to_neg();
      @(negedge clk);
   endtask

   task automatic fin();
      bookkeep();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic step();
      to_neg();
      fin();
   endtask

   // Reference: CRC over the frame's byte stream, non-eop beats always contribute all 8 bytes.
   task automatic push_frame(input int r, input int nb, input logic [7:0] mid_vb,
                             input logic [7:0] eop_vb, input int gap);
      logic [15:0] c;
      int          cnt;
      beat_t       b;
      res_t        e;
      c   = IV;
      cnt = 0;
      for (int k = 0; k < nb; k++) begin
         b.d   = {$urandom, $urandom};
         b.eop = (k == nb-1);
         b.vb  = b.eop ? eop_vb : mid_vb;
         b.gap = (k == 1) ? gap : 0;
         src_q[r].push_back(b);
         for (int j = 0; j < 8; j++) begin
            if (!b.eop || eop_vb[j]) begin
               c = crc_byte(c, b.d[8*j +: 8]);
               cnt++;
            end
         end
      end
      e.crc = c;
      e.nb  = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
      exp_q[r].push_back(e);
      drive();
   endtask

   task automatic wait_done(input int max);
      int n;
      n = 0;
      while ((busy || pending()) && n < max) begin
         step();
         n++;
      end
      chk("completion_timeout", (n < max), 1);
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) begin
         src_q[i].delete();
         exp_q[i].delete();
         gap_left[i] = 0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_all();
      drive();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_ord [8];
      int n, bub;
      rst = 1'b1; req_valid = '0; req_data = '0; req_vbytes = '0; req_eop = '0; res_ready = 1'b1;
      clear_all();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_crc_enable", crc_enable, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_crc_init", crc_init, 0);
      chk("rst_data_valid", crc_data_valid, 0);
      chk("rst_res_fields", {res_crc, res_nbytes, 14'd0, res_id}, 0);
      rst = 1'b0;
      to_neg();
      chk("enable_before_edge", crc_enable, 0);
      @(posedge clk);
      #1;
      chk("enable_after_edge", crc_enable, 1);

      // Single beat frame, cycle-accurate
      push_frame(0, 1, 8'hFF, 8'h0F, 0);
      to_neg(); chk("c0_busy", busy, 0); chk("c0_init", crc_init, 0); fin();
      to_neg(); chk("c1_init", crc_init, 1); chk("c1_init_value", crc_init_value, IV);
      chk("c1_ready", req_ready, 0); fin();
      to_neg(); chk("c2_data_valid", crc_data_valid, 1); chk("c2_vbytes", crc_data_vbytes, 8'h0F);
      chk("c2_ready", req_ready, 4'b0001); fin();
      to_neg(); chk("c3_flush_idle_engine", {crc_data_valid, res_valid, req_ready}, 0); fin();
      to_neg(); chk("c4_res_valid", res_valid, 1); chk("c4_res_id", res_id, 0);
      chk("c4_res_nbytes", res_nbytes, 4); fin();
      to_neg(); chk("c5_idle", {busy, res_valid}, 0); fin();

      // Forced full-word vbytes on non-eop beats
      eng_vb.delete();
      push_frame(2, 3, 8'h01, 8'h07, 0);
      wait_done(50);
      chk("eng_beats", eng_vb.size(), 3);
      chk("eng_vb0", (eng_vb.size() > 0) ? eng_vb[0] : 8'h00, 8'hFF);
      chk("eng_vb1", (eng_vb.size() > 1) ? eng_vb[1] : 8'h00, 8'hFF);
      chk("eng_vb2", (eng_vb.size() > 2) ? eng_vb[2] : 8'h00, 8'h07);

      // Arbitration order with every requester continuously valid
      do_reset();
      got_ids.delete();
      for (int r = 0; r < N; r++) begin
         push_frame(r, 1, 8'hFF, 8'($urandom_range(1, 255)), 0);
         push_frame(r, 1, 8'hFF, 8'($urandom_range(1, 255)), 0);
      end
`ifdef CR_CRC16T_SCHED_STRICT_PRIO_EN
      exp_ord = '{0, 0, 1, 1, 2, 2, 3, 3};
`else
      exp_ord = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
      wait_done(200);
      for (int k = 0; k < 8; k++) chk("grant_order", (got_ids.size() > k) ? got_ids[k] : -1, exp_ord[k]);

      // Result back-pressure
      got_ids.delete();
      res_ready = 1'b0;
      push_frame(1, 2, 8'hFF, 8'hFF, 0);
      push_frame(3, 1, 8'hFF, 8'h81, 0);
      n = 0;
      while (!res_valid && n < 20) begin step(); n++; end
      chk("bp_reach_result", res_valid, 1);
      for (int k = 0; k < 10; k++) begin
         to_neg();
         chk("bp_res_valid", res_valid, 1);
         chk("bp_res_id", res_id, 1);
         chk("bp_res_crc", res_crc, (exp_q[1].size() > 0) ? exp_q[1][0].crc : 16'h0000);
         chk("bp_req_ready", req_ready, 0);
         fin();
      end
      res_ready = 1'b1;
      to_neg(); chk("bp_still_valid", res_valid, 1); fin();
      to_neg(); chk("bp_idle_after_accept", busy, 0); fin();
      to_neg(); chk("bp_next_init", crc_init, 1); fin();
      wait_done(50);
      chk("bp_order_len", got_ids.size(), 2);
      chk("bp_second_id", (got_ids.size() > 1) ? got_ids[1] : -1, 3);

      // Mid-frame bubble of three cycles
      push_frame(0, 4, 8'hFF, 8'h3C, 3);
      n = 0;
      bub = 0;
      while ((busy || pending()) && n < 60) begin
         to_neg();
         if (|req_ready && !crc_data_valid) bub++;
         fin();
         n++;
      end
      chk("bubble_cycles", bub, 3);

      // Asynchronous reset in the middle of a frame
      push_frame(2, 5, 8'hFF, 8'hFF, 0);
      n = 0;
      while (!(|req_ready) && n < 20) begin step(); n++; end
      step();
      step();
      chk("pre_rst_in_data", |req_ready, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_ready", req_ready, 0);
      chk("arst_engine_ctl", {crc_data_valid, crc_init, crc_enable}, 0);
      chk("arst_res", {res_valid, res_crc, res_nbytes, 13'd0, res_id}, 0);
      clear_all();
      drive();
      @(posedge clk);
      #1;
      rst = 1'b0;
      push_frame(2, 2, 8'hFF, 8'hA5, 0);
      wait_done(50);

      // Byte-count saturation
      push_frame(1, 8200, 8'hFF, 8'hFF, 0);
      wait_done(9000);

      // Randomized traffic with random result acceptance
      rand_rdy = 1'b1;
      push_frame(3, 1, 8'hFF, 8'h00, 0);
      for (int k = 0; k < 12; k++)
         push_frame($urandom_range(0, N-1), $urandom_range(1, 4), 8'($urandom),
                    8'($urandom), $urandom_range(0, 2));
      wait_done(2000);
      rand_rdy = 1'b0;
      res_ready = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cr_crc16t_sched.md
Name: cr_crc16t_sched

Overview:
- Frame-granular round-robin scheduler that shares one CRC16T engine (64-bit data, 8-bit vbytes, init/init_value/enable, 1-cycle registered crc) between N_REQ streaming requesters.
- Per frame: issues an init pulse, forwards the granted requester's beats, waits one flush cycle for the engine register, then returns the CRC, requester id and byte count on a result handshake.
- Sits between the compression-side framers and the shared CRC16T instance.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- INIT_VALUE, 16'h0000, value driven on crc_init_value during the INIT cycle
- ID_W, $clog2(N_REQ), width of res_id

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  N_REQ  beat valid per requester
- req_data  in  N_REQ*64  beat data, requester i at [64*i +: 64]
- req_vbytes  in  N_REQ*8  byte-valid mask, requester i at [8*i +: 8]
- req_eop  in  N_REQ  last beat of frame
- req_ready  out  N_REQ  beat accepted when valid&ready
- crc_data_in  out  64  to engine data_in
- crc_data_valid  out  1  to engine data_valid
- crc_data_vbytes  out  8  to engine data_vbytes
- crc_enable  out  1  to engine enable
- crc_init  out  1  to engine init
- crc_init_value  out  16  to engine init_value
- crc_in  in  16  engine crc output
- res_valid  out  1  result valid
- res_ready  in  1  result accepted when valid&ready
- res_crc  out  16  frame CRC
- res_id  out  ID_W  requester that owned the frame
- res_nbytes  out  16  bytes in frame, saturating
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0, grant=0, res_valid=0, res_crc/res_id/res_nbytes=0, crc_enable=0, all req_ready=0, crc_init=0, crc_data_valid=0. crc_enable is registered: 1 from the first clock edge after rst deasserts.
- States: IDLE -> INIT -> DATA -> FLUSH -> RESULT -> IDLE.
- IDLE: if any req_valid, pick the first set bit searching upward from rr_ptr (wrapping); register it into grant; go to INIT. If none, stay. req_valid is only sampled; no beat is consumed in IDLE.
- INIT: one cycle; crc_init=1, crc_init_value=INIT_VALUE; nbytes cleared to 0; go to DATA.
- DATA: req_ready[grant]=1, all others 0. crc_data_valid = req_valid[grant]. crc_data_in = req_data[grant], combinational.
- DATA vbytes rule: crc_data_vbytes = req_vbytes[grant] on an eop beat, 8'hFF on non-eop beats (forced).
- DATA byte count: nbytes += popcount(effective vbytes), saturating at 16'hFFFF.
- DATA bubbles: req_valid low keeps DATA with crc_data_valid=0. No timeout.
- DATA exit: accepted beat with req_eop goes to FLUSH. An eop beat with vbytes=0 is legal; the CRC is unchanged by it.
- FLUSH: one cycle with no engine activity, because the engine register now holds the final value. Capture res_crc=crc_in, res_id=grant, res_nbytes=nbytes; go to RESULT.
- RESULT: res_valid=1 and outputs stable. On res_ready: res_valid=0, rr_ptr=(grant+1) mod N_REQ, go to IDLE. Back-pressure holds RESULT indefinitely with all req_ready=0.
- Outside INIT, crc_init=0. Outside DATA, crc_data_valid=0, req_ready=0, crc_data_in=0, crc_data_vbytes=0.
- Minimum frame turnaround: 5 cycles for a 1-beat frame with res_ready held high.
- Latency: request seen in IDLE at cycle 0, INIT at 1, first beat at 2 earliest, eop beat at k, FLUSH at k+1, res_valid at k+2.
- Simultaneous events: new req_valid while in RESULT is not granted until IDLE. The res_ready handshake and the next IDLE arbitration are on separate cycles.

Optional Feature:
- Macro: CR_CRC16T_SCHED_STRICT_PRIO_EN.
- Defined: IDLE arbitration is fixed priority, lowest index wins. rr_ptr is removed.
- Undefined: round-robin as specified above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then req_valid[0] with one beat, eop=1, vbytes=8'h0F -> crc_init at cycle 1 with value INIT_VALUE; crc_data_valid at cycle 2 with vbytes 8'h0F; res_valid at cycle 4, res_id=0, res_nbytes=4, res_crc matches the engine model.
- Requester 2 sends a 3-beat frame, non-eop vbytes=8'h01, eop vbytes=8'h07 -> engine sees 8'hFF, 8'hFF, 8'h07; res_nbytes=19.
- All 4 requesters hold valid continuously with 1-beat frames -> result ids 0,1,2,3,0 in that order. With the macro defined: 0,0,0...
- res_ready held low for 10 cycles in RESULT -> res_valid and res_crc stable; req_ready=0 throughout; next grant only after acceptance.
- req_valid[grant] drops for 3 cycles mid-frame -> crc_data_valid=0 on those cycles; final CRC equals the gap-free run.
- rst pulsed during DATA -> all outputs return to reset values asynchronously; the next frame after reset produces the correct CRC from INIT_VALUE.
